// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lets two requesters share one external ALU.
// A grant captures the winner's op and operands, EXEC drives the ALU, and DONE presents the result.
module alu_arbiter #(
  parameter int ALU_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [3:0]  op0,
  input  logic [3:0]  op1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  input  logic [31:0] aluResult,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] result,
  output logic        resZero,
  output logic        opErr,
  output logic        busy,
  output logic [3:0]  aluControl,
  output logic [31:0] readData1,
  output logic [31:0] readData2
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        lastGnt_q, lastGnt_d;
  logic        owner_q, owner_d;
  logic        err_q, err_d;
  logic [3:0]  aluCtl_q, aluCtl_d;
  logic [31:0] rd1_q, rd1_d;
  logic [31:0] rd2_q, rd2_d;
  logic [31:0] result_q, result_d;
  logic        resZero_q, resZero_d;
  logic        opErr_q, opErr_d;

  logic        grant0, grant1;
  logic [3:0]  selOp;
  logic [31:0] selA, selB;
  logic [31:0] capVal;

  function automatic logic opSupported(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1000: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

  // lastGnt_q == 1 means requester 1 won last, so requester 0 is preferred on a tie.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE && reset) begin
      if (req0 && (!req1 || lastGnt_q)) grant0 = 1'b1;
      else if (req1)                    grant1 = 1'b1;
    end
  end

  assign selOp  = grant1 ? op1 : op0;
  assign selA   = grant1 ? a1  : a0;
  assign selB   = grant1 ? b1  : b0;
  assign capVal = err_q ? 32'd0 : aluResult;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lastGnt_d = lastGnt_q;
    owner_d   = owner_q;
    err_d     = err_q;
    aluCtl_d  = aluCtl_q;
    rd1_d     = rd1_q;
    rd2_d     = rd2_q;
    result_d  = result_q;
    resZero_d = resZero_q;
    opErr_d   = opErr_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          state_d   = EXEC;
          cnt_d     = 4'(ALU_LATENCY - 1);
          lastGnt_d = grant1;
          owner_d   = grant1;
          err_d     = !opSupported(selOp);
          // Unsupported ops leave the ALU idle on code 0000 with its operands untouched.
          if (opSupported(selOp)) begin
            aluCtl_d = selOp;
            rd1_d    = selA;
            rd2_d    = selB;
          end else begin
            aluCtl_d = 4'b0000;
          end
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d   = DONE;
          result_d  = capVal;
          resZero_d = (capVal == 32'd0);
          opErr_d   = err_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      lastGnt_q <= 1'b1;
      owner_q   <= 1'b0;
      err_q     <= 1'b0;
      aluCtl_q  <= 4'd0;
      rd1_q     <= 32'd0;
      rd2_q     <= 32'd0;
      result_q  <= 32'd0;
      resZero_q <= 1'b0;
      opErr_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lastGnt_q <= lastGnt_d;
      owner_q   <= owner_d;
      err_q     <= err_d;
      aluCtl_q  <= aluCtl_d;
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
      result_q  <= result_d;
      resZero_q <= resZero_d;
      opErr_q   <= opErr_d;
    end
  end

  assign gnt0       = grant0;
  assign gnt1       = grant1;
  assign done0      = (state_q == DONE) && !owner_q;
  assign done1      = (state_q == DONE) && owner_q;
  assign busy       = (state_q != IDLE);
  assign result     = result_q;
  assign resZero    = resZero_q;
  assign opErr      = opErr_q;
  assign aluControl = aluCtl_q;
  assign readData1  = rd1_q;
  assign readData2  = rd2_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a cycle-level model predicts grants and pushes expected results,
// a monitor pops them on done. A second instance with latency 3 covers reset abort.
module tb_alu_arbiter;

  localparam int L  = 1;
  localparam int L3 = 3;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SUB = 4'b1000;

  logic        clock;
  logic        reset, reset3;
  logic        req0, req1, req0_3, req1_3;
  logic [3:0]  op0, op1;
  logic [31:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, done0, done1, resZero, opErr, busy;
  logic [31:0] result, readData1, readData2, aluResult;
  logic [3:0]  aluControl;
  logic        gnt0_3, gnt1_3, done0_3, done1_3, resZero3, opErr3, busy3;
  logic [31:0] result3, rd1_3, rd2_3, aluResult3;
  logic [3:0]  aluControl3;
  logic [31:0] pipe3 [0:1];

  typedef struct {
    logic        who;
    logic [31:0] res;
    logic        err;
    int          due;
  } exp_t;

  exp_t        expQ[$];
  int          cyc;
  int          checks;
  int          errors;
  int          nextFree;
  int          lastW;
  bit          monitorOn;
  bit          granted;
  bit          haveLast;
  logic [31:0] lastRes;
  logic        lastErr;

  function automatic logic [31:0] aluFn(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_ADD:  return x + y;
      OP_SHL:  return x << y[4:0];
      OP_SUB:  return x - y;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit opSupp(input logic [3:0] op);
    return op == OP_AND || op == OP_OR || op == OP_ADD || op == OP_SHL || op == OP_SUB;
  endfunction

  function automatic logic [3:0] randOp();
    case ($urandom_range(0, 5))
      0:       return OP_AND;
      1:       return OP_OR;
      2:       return OP_ADD;
      3:       return OP_SHL;
      4:       return OP_SUB;
      default: return 4'($urandom);
    endcase
  endfunction

  alu_arbiter #(.ALU_LATENCY(L)) dut (
    .clock(clock), .reset(reset), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .aluResult(aluResult),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .result(result),
    .resZero(resZero), .opErr(opErr), .busy(busy), .aluControl(aluControl),
    .readData1(readData1), .readData2(readData2)
  );

  alu_arbiter #(.ALU_LATENCY(L3)) dut3 (
    .clock(clock), .reset(reset3), .req0(req0_3), .req1(req1_3), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .aluResult(aluResult3),
    .gnt0(gnt0_3), .gnt1(gnt1_3), .done0(done0_3), .done1(done1_3), .result(result3),
    .resZero(resZero3), .opErr(opErr3), .busy(busy3), .aluControl(aluControl3),
    .readData1(rd1_3), .readData2(rd2_3)
  );

  // The single-cycle ALU answers combinationally; the latency-3 ALU only settles after two register stages.
  assign aluResult  = aluFn(aluControl, readData1, readData2);
  assign aluResult3 = pipe3[1];

  always @(posedge clock) begin
    pipe3[0] <= aluFn(aluControl3, rd1_3, rd2_3);
    pipe3[1] <= pipe3[0];
    cyc      <= cyc + 1;
  end

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus on the latency-1 instance; the model decides the grant from this cycle's requests.
  task automatic applyStimulus(input logic r0, input logic [3:0] o0, input logic [31:0] x0, input logic [31:0] y0,
                               input logic r1, input logic [3:0] o1, input logic [31:0] x1, input logic [31:0] y1);
    int   win;
    bit   idle;
    exp_t e;
    @(negedge clock);
    req0 = r0; op0 = o0; a0 = x0; b0 = y0;
    req1 = r1; op1 = o1; a1 = x1; b1 = y1;
    #1;
    idle = (cyc >= nextFree);
    win  = -1;
    if (idle) begin
      if (r0 && r1)  win = (lastW == 0) ? 1 : 0;
      else if (r0)   win = 0;
      else if (r1)   win = 1;
    end
    checkOutput("gnt0", 32'(gnt0), 32'(win == 0));
    checkOutput("gnt1", 32'(gnt1), 32'(win == 1));
    checkOutput("busy", 32'(busy), 32'(!idle));
    granted = (win >= 0);
    if (win >= 0) begin
      lastW    = win;
      nextFree = cyc + L + 2;
      e.who    = (win == 1);
      e.res    = (win == 1) ? aluFn(o1, x1, y1) : aluFn(o0, x0, y0);
      e.err    = (win == 1) ? !opSupp(o1) : !opSupp(o0);
      e.due    = cyc + L + 1;
      expQ.push_back(e);
    end
  endtask

  task automatic issueReq(input logic who, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (who) applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, op, x, y);
      else     applyStimulus(1'b1, op, x, y, 1'b0, 4'd0, 32'd0, 32'd0);
      ok = granted;
    end
    if (!ok) checkOutput("grant wait", 32'd0, 32'd1);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  // Monitor: every done pops one expectation; between dones the result registers must hold.
  always @(negedge clock) begin
    if (monitorOn) begin
      if (done0 || done1) begin
        checkOutput("single done", 32'(done0 & done1), 32'd0);
        if (expQ.size() == 0) begin
          checkOutput("unexpected done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("done owner", 32'(done1), 32'(e.who));
          checkOutput("done cycle", 32'(cyc), 32'(e.due));
          checkOutput("result", result, e.res);
          checkOutput("resZero", 32'(resZero), 32'(e.res == 32'd0));
          checkOutput("opErr", 32'(opErr), 32'(e.err));
          lastRes  = e.res;
          lastErr  = e.err;
          haveLast = 1'b1;
        end
      end else begin
        if (expQ.size() > 0 && expQ[0].due < cyc) begin
          checkOutput("done timeout", 32'd0, 32'd1);
          void'(expQ.pop_front());
        end
        if (haveLast) begin
          checkOutput("result hold", result, lastRes);
          checkOutput("opErr hold", 32'(opErr), 32'(lastErr));
        end
      end
    end
  end

  initial begin
    bit found;
    bit sawDone;
    checks = 0; errors = 0; cyc = 0; nextFree = 0; lastW = 1;
    monitorOn = 1'b0; granted = 1'b0; haveLast = 1'b0;
    lastRes = 32'd0; lastErr = 1'b0;
    reset = 1'b0; reset3 = 1'b0;
    req0 = 1'b0; req1 = 1'b0; req0_3 = 1'b0; req1_3 = 1'b0;
    op0 = 4'd0; op1 = 4'd0; a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0;

    // Requests during reset must not leak through as grants.
    @(negedge clock);
    req0 = 1'b1; req1 = 1'b1; op0 = OP_ADD; a0 = 32'd9;
    #1;
    checkOutput("reset gnt0", 32'(gnt0), 32'd0);
    checkOutput("reset gnt1", 32'(gnt1), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'({done0, done1}), 32'd0);
    checkOutput("reset result", result, 32'd0);
    checkOutput("reset flags", 32'({resZero, opErr}), 32'd0);
    checkOutput("reset aluControl", 32'(aluControl), 32'd0);
    checkOutput("reset readData", readData1 | readData2, 32'd0);
    @(negedge clock);
    req0 = 1'b0; req1 = 1'b0;
    reset = 1'b1;
    monitorOn = 1'b1;

    $display("[TB] both requesters held high: alternating grants");
    for (int i = 0; i < 12; i++)
      applyStimulus(1'b1, OP_ADD, 32'(i), 32'd100, 1'b1, OP_OR, 32'(i), 32'h100);
    idleCycles(L + 2);

    $display("[TB] single ADD 5+7");
    issueReq(1'b0, OP_ADD, 32'd5, 32'd7);
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
    checkOutput("exec aluControl", 32'(aluControl), 32'(OP_ADD));
    checkOutput("exec readData1", readData1, 32'd5);
    checkOutput("exec readData2", readData2, 32'd7);
    idleCycles(L + 2);

    $display("[TB] wrap-around zero results and unsupported op");
    issueReq(1'b1, OP_SUB, 32'h8000_0000, 32'h8000_0000);
    issueReq(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'd1);
    issueReq(1'b0, OP_SHL, 32'h0000_0003, 32'd31);
    issueReq(1'b0, 4'b1111, 32'd1, 32'd2);
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
    checkOutput("bad op aluControl", 32'(aluControl), 32'd0);
    idleCycles(L + 2);

    $display("[TB] cancelled request and operands changed after grant");
    issueReq(1'b1, OP_ADD, 32'd3, 32'd4);
    applyStimulus(1'b1, OP_OR, 32'd1, 32'd1, 1'b0, OP_SUB, 32'd100, 32'd50);
    applyStimulus(1'b0, OP_OR, 32'd1, 32'd1, 1'b0, OP_SUB, 32'd200, 32'd60);
    idleCycles(L + 3);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 300; i++)
      applyStimulus($urandom_range(0, 2) != 0, randOp(), $urandom(), ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom(),
                    $urandom_range(0, 2) != 0, randOp(), $urandom(), $urandom_range(0, 40));
    idleCycles(L + 3);
    checkOutput("queue drained", 32'(expQ.size()), 32'd0);
    monitorOn = 1'b0;

    $display("[TB] latency-3 instance: reset during EXEC");
    @(negedge clock);
    reset3 = 1'b1;
    @(negedge clock);
    req1_3 = 1'b1; op1 = OP_ADD; a1 = 32'd1; b1 = 32'd2;
    #1 checkOutput("l3 first gnt1", 32'(gnt1_3), 32'd1);
    @(negedge clock);
    req1_3 = 1'b0;
    #1 checkOutput("l3 busy exec", 32'(busy3), 32'd1);
    @(negedge clock);
    reset3 = 1'b0;
    #1;
    checkOutput("l3 abort busy", 32'(busy3), 32'd0);
    checkOutput("l3 abort aluControl", 32'(aluControl3), 32'd0);
    checkOutput("l3 abort readData1", rd1_3, 32'd0);
    sawDone = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (done0_3 || done1_3) sawDone = 1'b1;
    end
    checkOutput("l3 no done after abort", 32'(sawDone), 32'd0);
    req1_3 = 1'b1; op1 = OP_ADD; a1 = 32'd10; b1 = 32'd20;
    @(negedge clock);
    reset3 = 1'b1;
    #1 checkOutput("l3 gnt1 after release", 32'(gnt1_3), 32'd1);
    @(negedge clock);
    req1_3 = 1'b0; a1 = 32'd77;
    #1 checkOutput("l3 busy after first edge", 32'(busy3), 32'd1);
    found = 1'b0;
    for (int k = 1; k <= 10 && !found; k++) begin
      if (done1_3) begin
        found = 1'b1;
        checkOutput("l3 done latency", 32'(k), 32'(L3 + 1));
        checkOutput("l3 result", result3, 32'd30);
        checkOutput("l3 flags", 32'({resZero3, opErr3, done0_3}), 32'd0);
      end else begin
        @(negedge clock);
      end
    end
    if (!found) checkOutput("l3 done timeout", 32'd0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: ALU_LATENCY, default 1, cycles from operands driven to the ALU until aluResult is valid (legal 1-15).
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req0 / req1  input  1  operation request from requester 0 / 1.
REQ-005 op0 / op1  input  4  ALU operation code of requester 0 / 1.
REQ-006 a0, b0 / a1, b1  input  32  operands of requester 0 / 1.
REQ-007 gnt0 / gnt1  output  1  one-cycle pulse: request accepted, operands captured.
REQ-008 done0 / done1  output  1  one-cycle pulse: result for requester 0 / 1 valid.
REQ-009 result  output  32  shared result, valid only while done0 or done1 is high.
REQ-010 resZero  output  1  high when result == 0, valid with done.
REQ-011 opErr  output  1  high with done when the captured op code is unsupported.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 aluControl  output  4; readData1, readData2  output  32  drive the shared ALU.
REQ-014 aluResult  input  32  ALU result.

Function
REQ-015 FSM states SHALL be IDLE, EXEC, DONE; IDLE -> EXEC on grant, EXEC -> DONE after ALU_LATENCY cycles, DONE -> IDLE unconditionally.
REQ-016 In IDLE, gntN SHALL be asserted combinationally in the same cycle reqN is sampled high and N wins arbitration; op/a/b of N are captured at that edge.
REQ-017 Arbitration SHALL be round-robin: single request wins; with both high, the requester not granted last wins; after reset requester 0 has priority.
REQ-018 At most one of gnt0/gnt1 and one of done0/done1 SHALL be high in any cycle; no grant outside IDLE.
REQ-019 In EXEC, aluControl/readData1/readData2 SHALL drive the captured op and operands, stable for all ALU_LATENCY cycles.
REQ-020 aluResult SHALL be registered into result at the edge ending the last EXEC cycle; done asserted the following cycle, i.e. ALU_LATENCY+1 cycles after the gnt cycle.
REQ-021 Supported ops: 0000 AND, 0001 OR, 0010 ADD, 0110 SHL, 1000 SUB; any other code SHALL skip the ALU: aluControl held at 0000, result = 0, opErr = 1, same latency.
REQ-022 resZero SHALL be computed locally from the registered 32-bit result; overflow/carry are discarded (32-bit wrap).
REQ-023 ALU drive outputs SHALL hold their last values outside EXEC.
REQ-024 Minimum issue interval SHALL be ALU_LATENCY+2 cycles; a request held high through its own DONE is treated as a new request in the next IDLE.
REQ-025 reqN deasserted before grant SHALL cancel it with no side effect; reqN/operand changes after grant SHALL be ignored.
REQ-026 result, resZero, opErr SHALL hold after DONE until the next capture.

Reset
REQ-027 reset low SHALL immediately force state IDLE, all outputs 0 (gnt, done, result, resZero, opErr, busy, aluControl, readData1, readData2) and priority to requester 0.
REQ-028 Reset during EXEC or DONE SHALL abort the operation with no done pulse; after release the arbiter accepts requests on the first clock edge.

Verification
REQ-029 ALU_LATENCY=1, req0 ADD a0=5 b0=7 -> gnt0 cycle 0, aluControl=0010 cycle 1, done0 cycle 2 with result=12, resZero=0, opErr=0.
REQ-030 req0 and req1 held high together after reset -> grants alternate 0,1,0,1, each done for the matching requester, issue interval 3 cycles.
REQ-031 req1 SUB a1=b1=0x80000000 -> result=0, resZero=1; req1 ADD 0xFFFFFFFF+1 -> result=0, resZero=1.
REQ-032 req0 op=1111 -> no ALU op code change, done0 with result=0, opErr=1.
REQ-033 ALU_LATENCY=3, reset pulled low in second EXEC cycle -> no done, busy=0 immediately, next req1 granted on first edge after release.
REQ-034 req0 dropped before grant while busy -> no gnt0 ever issued for it; operands changed after gnt1 -> result reflects captured values.
